bus_ram_ws: RTL and testbench

// Parametrised synchronous RAM slave on the shared tristate sysbus, using MAR/MDR.

---
 rtl/bus_ram_ws.sv | 206 ++++++++++++++++++++
 tb/tb_bus_ram_ws.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram_ws.sv
// bus_ram_ws: synchronous RAM slave on the shared tristate sysbus.
// It is accessed through MAR/MDR. Features:
//   - configurable base address and depth;
//   - programmable wait states with a ready handshake;
//   - MAR auto-increment for streaming;
//   - a write-protected address window with a sticky wr_err flag.
module bus_ram_ws #(
    parameter int WORD_W      = 10,
    parameter int OP_W        = 3,
    parameter int BASE        = 64,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0,
    parameter int PROT_LO     = 80,
    parameter int PROT_HI     = 80
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              MDR_bus,
    input  logic              load_MDR,
    input  logic              load_MAR,
    input  logic              inc_MAR,
    input  logic              CS,
    input  logic              R_NW,
    inout  wire  [WORD_W-1:0] sysbus,
    output logic              ready,
    output logic              wr_err
);

    localparam int ADDR_W = WORD_W - OP_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Address comparisons use one extra bit so BASE+DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   BASE_X    = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0]   LIMIT_X   = (ADDR_W+1)'(BASE + DEPTH);
    localparam logic [ADDR_W:0]   PROT_LO_X = (ADDR_W+1)'(PROT_LO);
    localparam logic [ADDR_W:0]   PROT_HI_X = (ADDR_W+1)'(PROT_HI);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);
    localparam logic [2:0]        WS_CNT    = 3'(WAIT_STATES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [ADDR_W-1:0] mar_r;
    logic [WORD_W-1:0] mdr_r;
    logic [0:0]        state_r;
    logic [2:0]        cnt_r;
    logic              rnw_r;
    logic              ready_r;
    logic              wr_err_r;
    logic [WORD_W-1:0] mem_r [0:DEPTH-1];

    logic [ADDR_W:0]   mar_ext_s;
    logic              sel_s;
    logic              prot_s;
    logic [IDX_W-1:0]  index_s;
    logic              act_lmar_s;
    logic              act_inc_s;
    logic              act_lmdr_s;
    logic              act_start_s;
    logic              access_s;
    logic              access_rnw_s;
    logic              mem_we_s;
    logic              err_set_s;

    // Decode: window select, protection hit and RAM index. All are derived from the full MAR.
    always_comb begin
        mar_ext_s = {1'b0, mar_r};
        sel_s     = (mar_ext_s >= BASE_X) && (mar_ext_s < LIMIT_X);
        prot_s    = (mar_ext_s >= PROT_LO_X) && (mar_ext_s <= PROT_HI_X);
        index_s   = IDX_W'(mar_r - BASE_A);
    end

    // Strobe arbitration in IDLE. One action per cycle; lower-priority strobes are dropped.
    always_comb begin
        act_lmar_s  = 1'b0;
        act_inc_s   = 1'b0;
        act_lmdr_s  = 1'b0;
        act_start_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (load_MAR) begin
                act_lmar_s = 1'b1;
            end else if (inc_MAR) begin
                act_inc_s = 1'b1;
            end else if (load_MDR) begin
                act_lmdr_s = 1'b1;
            end else if (CS && sel_s) begin
                act_start_s = 1'b1;
            end else begin
                act_start_s = 1'b0;
            end
        end else begin
            act_start_s = 1'b0;
        end
    end

    // Access timing. The access happens either at the CS edge (no wait states)
    // or at the last WAIT edge, using the direction latched at the start.
    always_comb begin
        access_s     = 1'b0;
        access_rnw_s = rnw_r;
        case (state_r)
            ST_IDLE: begin
                access_rnw_s = R_NW;
                if (act_start_s && (WS_CNT == 3'd0)) begin
                    access_s = 1'b1;
                end else begin
                    access_s = 1'b0;
                end
            end
            ST_WAIT: begin
                access_rnw_s = rnw_r;
                if (cnt_r <= 3'd1) begin
                    access_s = 1'b1;
                end else begin
                    access_s = 1'b0;
                end
            end
            default: begin
                access_s     = 1'b0;
                access_rnw_s = rnw_r;
            end
        endcase
        mem_we_s  = access_s && !access_rnw_s && !prot_s;
        err_set_s = access_s && !access_rnw_s && prot_s;
    end

    // MAR/MDR registers. While WAIT is active both hold, because no act_* fires there.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            mar_r <= {ADDR_W{1'b0}};
            mdr_r <= {WORD_W{1'b0}};
        end else begin
            if (act_lmar_s) begin
                mar_r <= sysbus[ADDR_W-1:0];
            end else if (act_inc_s) begin
                mar_r <= mar_r + ADDR_W'(1);
            end
            if (act_lmdr_s) begin
                mdr_r <= sysbus;
            end else if (access_s && access_rnw_s) begin
                mdr_r <= mem_r[index_s];
            end
        end
    end

    // Access sequencer. It counts down the wait states and drives the registered ready.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            rnw_r   <= 1'b1;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (act_start_s) begin
                        rnw_r <= R_NW;
                    end
                    if (act_start_s && (WS_CNT != 3'd0)) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= WS_CNT;
                        ready_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r <= 3'd1) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 3'd0;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Sticky protection error. It is cleared by an accepted CS.
    // A protected write in that same cycle sets it again.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            wr_err_r <= 1'b0;
        end else if (err_set_s) begin
            wr_err_r <= 1'b1;
        end else if (act_start_s) begin
            wr_err_r <= 1'b0;
        end
    end

    // Memory array write port. Its contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[index_s] <= mdr_r;
        end
    end

    assign sysbus = (MDR_bus && sel_s) ? mdr_r : {WORD_W{1'bz}};
    assign ready  = ready_r;
    assign wr_err = wr_err_r;

endmodule

// File: tb/tb_bus_ram_ws.sv
// Testbench for bus_ram_ws. It runs three instances with 0, 2 and 3 wait states,
// and checks them against a table, hand-written sequences and a memory-level model.
module tb_bus_ram_ws;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0] n_reset, mdr_bus, load_mdr, load_mar, inc_mar, cs, r_nw, drv_en;
    logic [9:0] drv_val [3];
    wire  [2:0] ready, wr_err;
    wire  [9:0] bus0, bus1, bus2;

    assign bus0 = drv_en[0] ? drv_val[0] : 10'bz;
    assign bus1 = drv_en[1] ? drv_val[1] : 10'bz;
    assign bus2 = drv_en[2] ? drv_val[2] : 10'bz;

    bus_ram_ws #(.WAIT_STATES(0)) u_ws0 (
        .clock(clock), .n_reset(n_reset[0]), .MDR_bus(mdr_bus[0]), .load_MDR(load_mdr[0]),
        .load_MAR(load_mar[0]), .inc_MAR(inc_mar[0]), .CS(cs[0]), .R_NW(r_nw[0]),
        .sysbus(bus0), .ready(ready[0]), .wr_err(wr_err[0]));
    bus_ram_ws #(.WAIT_STATES(2)) u_ws2 (
        .clock(clock), .n_reset(n_reset[1]), .MDR_bus(mdr_bus[1]), .load_MDR(load_mdr[1]),
        .load_MAR(load_mar[1]), .inc_MAR(inc_mar[1]), .CS(cs[1]), .R_NW(r_nw[1]),
        .sysbus(bus1), .ready(ready[1]), .wr_err(wr_err[1]));
    bus_ram_ws #(.WAIT_STATES(3)) u_ws3 (
        .clock(clock), .n_reset(n_reset[2]), .MDR_bus(mdr_bus[2]), .load_MDR(load_mdr[2]),
        .load_MAR(load_mar[2]), .inc_MAR(inc_mar[2]), .CS(cs[2]), .R_NW(r_nw[2]),
        .sysbus(bus2), .ready(ready[2]), .wr_err(wr_err[2]));

    // Reference model: memory indexed by full address, plus MAR/MDR/error per instance.
    logic [9:0] m_mem [3][128];
    bit         m_val [3][128];
    logic [6:0] m_mar [3];
    logic [9:0] m_mdr [3];
    bit         m_mdr_ok [3];
    bit         m_err [3];
    int         ws_of [3] = '{0, 2, 3};
    int         n_checks = 0;
    int         n_errors = 0;

    typedef struct {
        bit         lmar, imar, lmdr, c, rnw;
        logic [9:0] val;
        bit         obs;
        logic [9:0] exp_bus;
        bit         exp_err;
    } vec_t;
    vec_t tbl [18];

    function automatic bit in_win(input logic [6:0] a);
        return (int'(a) >= 64) && (int'(a) < 64 + 64);
    endfunction

    function automatic bit in_prot(input logic [6:0] a);
        return (int'(a) >= 80) && (int'(a) <= 80);
    endfunction

    function automatic logic [9:0] get_bus(input int d);
        case (d)
            0: return bus0;
            1: return bus1;
            default: return bus2;
        endcase
    endfunction

    function automatic logic [6:0] peek_mar(input int d);
        case (d)
            0: return u_ws0.mar_r;
            1: return u_ws2.mar_r;
            default: return u_ws3.mar_r;
        endcase
    endfunction

    task automatic chk(input bit ok, input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_mar[d] = 7'd0; m_mdr[d] = 10'd0; m_mdr_ok[d] = 1'b1; m_err[d] = 1'b0;
    endtask

    task automatic clear_strobes(input int d);
        load_mar[d] = 1'b0; inc_mar[d] = 1'b0; load_mdr[d] = 1'b0;
        cs[d] = 1'b0; r_nw[d] = 1'b0; drv_en[d] = 1'b0;
    endtask

    // Drive MDR_bus briefly; the bus must show mdr in the window, otherwise anything but mdr.
    task automatic observe(input int d, input string name);
        logic [9:0] b;
        mdr_bus[d] = 1'b1;
        #1;
        b = get_bus(d);
        if (in_win(m_mar[d])) begin
            if (m_mdr_ok[d]) chk(b === m_mdr[d], {name, "_bus"}, b, m_mdr[d]);
        end else if (m_mdr_ok[d] && (m_mdr[d] != 10'd0)) begin
            chk(b !== m_mdr[d], {name, "_hiz"}, b, m_mdr[d]);
        end
        mdr_bus[d] = 1'b0;
    endtask

    // One IDLE cycle of strobes. If an access is accepted, wait out the busy
    // period while throwing junk strobes at the DUT.
    task automatic strobe(input int d, input bit lmar, input bit imar, input bit lmdr,
                          input bit c, input bit rnw, input logic [9:0] val, input string name);
        bit acc;
        load_mar[d] = lmar; inc_mar[d] = imar; load_mdr[d] = lmdr; cs[d] = c; r_nw[d] = rnw;
        drv_val[d] = val; drv_en[d] = lmar | lmdr;
        @(posedge clock);
        acc = 1'b0;
        if (lmar) m_mar[d] = val[6:0];
        else if (imar) m_mar[d] = m_mar[d] + 7'd1;
        else if (lmdr) begin m_mdr[d] = val; m_mdr_ok[d] = 1'b1; end
        else if (c && in_win(m_mar[d])) begin
            acc = 1'b1;
            m_err[d] = 1'b0;
            if (rnw) begin
                m_mdr[d] = m_mem[d][m_mar[d]]; m_mdr_ok[d] = m_val[d][m_mar[d]];
            end else if (in_prot(m_mar[d])) begin
                m_err[d] = 1'b1;
            end else begin
                m_mem[d][m_mar[d]] = m_mdr[d]; m_val[d][m_mar[d]] = m_mdr_ok[d];
            end
        end
        @(negedge clock);
        clear_strobes(d);
        if (acc) begin
            for (int k = 0; k < ws_of[d]; k++) begin
                chk(ready[d] === 1'b0, {name, "_busy"}, 10'(ready[d]), 10'd0);
                load_mdr[d] = 1'b1; drv_val[d] = 10'h3FF; drv_en[d] = 1'b1;
                load_mar[d] = 1'($urandom_range(0, 1)); inc_mar[d] = 1'($urandom_range(0, 1));
                cs[d] = 1'($urandom_range(0, 1)); r_nw[d] = 1'($urandom_range(0, 1));
                @(posedge clock);
                @(negedge clock);
                clear_strobes(d);
            end
        end
        chk(ready[d] === 1'b1, {name, "_ready"}, 10'(ready[d]), 10'd1);
        chk(wr_err[d] === m_err[d], {name, "_err"}, 10'(wr_err[d]), 10'(m_err[d]));
        observe(d, name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] cv [8];
        logic [9:0] b;
        for (int d = 0; d < 3; d++) begin
            clear_strobes(d);
            mdr_bus[d] = 1'b0; drv_val[d] = 10'd0;
            model_reset(d);
            for (int a = 0; a < 128; a++) begin m_val[d][a] = 1'b0; m_mem[d][a] = 10'd0; end
        end
        n_reset = 3'b000;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            chk(ready[d] === 1'b1, "rst_ready", 10'(ready[d]), 10'd1);
            chk(wr_err[d] === 1'b0, "rst_err", 10'(wr_err[d]), 10'd0);
        end
        n_reset = 3'b111;
        @(negedge clock);

        // Table: basic write/read, protection, strobe priority, wrap (WS=0 instance).
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h041, 1'b1, 10'h000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h2A5, 1'b1, 10'h2A5, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h2A5, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 1'b1, 10'h2A5, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h050, 1'b1, 10'h2A5, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0FF, 1'b1, 10'h0FF, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h0FF, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h041, 1'b1, 10'h0FF, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 1'b1, 10'h2A5, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3D0, 1'b1, 10'h2A5, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h2A5, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h3FF, 1'b1, 10'h2A5, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h2A5, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h155, 1'b1, 10'h155, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h07F, 1'b1, 10'h155, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000, 1'b0};
        for (int i = 0; i < 18; i++) begin
            strobe(0, tbl[i].lmar, tbl[i].imar, tbl[i].lmdr, tbl[i].c, tbl[i].rnw, tbl[i].val, "tbl");
            chk(wr_err[0] === tbl[i].exp_err, "tbl_vec_err", 10'(wr_err[0]), 10'(tbl[i].exp_err));
            if (tbl[i].obs) begin
                mdr_bus[0] = 1'b1;
                #1;
                b = bus0;
                chk(b === tbl[i].exp_bus, "tbl_vec_bus", b, tbl[i].exp_bus);
                mdr_bus[0] = 1'b0;
            end
        end
        chk(peek_mar(0) === 7'd0, "wrap_mar0", 10'(peek_mar(0)), 10'd0);

        // Wait states: write 0x111 @70, then read it back through the busy periods.
        strobe(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h046, "ws_mar");
        strobe(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h111, "ws_mdr");
        strobe(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, "ws_wr");
        strobe(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, "ws_mdr0");
        strobe(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, "ws_rd");
        mdr_bus[1] = 1'b1; #1; b = bus1;
        chk(b === 10'h111, "ws_read_value", b, 10'h111);
        mdr_bus[1] = 1'b0;

        // Protected write @80 on the wait-state instance.
        strobe(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h050, "pr_mar");
        strobe(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0FF, "pr_mdr");
        strobe(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, "pr_wr");
        chk(wr_err[1] === 1'b1, "pr_err_set", 10'(wr_err[1]), 10'd1);
        strobe(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, "pr_rd");
        chk(wr_err[1] === 1'b0, "pr_err_clr", 10'(wr_err[1]), 10'd0);
        mdr_bus[1] = 1'b1; #1; b = bus1;
        chk(b !== 10'h0FF, "pr_old_value", b, 10'h0FF);
        mdr_bus[1] = 1'b0;

        // Streaming eight characters with auto-increment.
        strobe(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h040, "st_mar");
        for (int i = 0; i < 8; i++) begin
            cv[i] = 10'($urandom_range(1, 1023));
            strobe(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cv[i], "st_mdr");
            strobe(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, "st_wr");
            strobe(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, "st_inc");
        end
        chk(peek_mar(0) === 7'd72, "st_mar72", 10'(peek_mar(0)), 10'd72);
        for (int i = 0; i < 8; i++) begin
            strobe(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'(64 + i), "st_rmar");
            strobe(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, "st_rd");
            mdr_bus[0] = 1'b1; #1; b = bus0;
            chk(b === cv[i], "st_readback", b, cv[i]);
            mdr_bus[0] = 1'b0;
        end
        strobe(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h07F, "st_m127");
        strobe(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, "st_wrap");
        chk(peek_mar(0) === 7'd0, "st_wrap0", 10'(peek_mar(0)), 10'd0);
        strobe(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, "st_cs0w");
        strobe(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, "st_cs0r");
        strobe(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h040, "st_back");
        strobe(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, "st_rd64");

        // Reset in the middle of a 3-wait-state write @66.
        strobe(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h042, "rs_mar");
        strobe(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h155, "rs_mdr");
        strobe(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, "rs_wr");
        strobe(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0AB, "rs_mdr2");
        cs[2] = 1'b1; r_nw[2] = 1'b0;
        @(posedge clock); @(negedge clock);
        cs[2] = 1'b0;
        chk(ready[2] === 1'b0, "rs_busy", 10'(ready[2]), 10'd0);
        @(posedge clock); @(negedge clock);
        n_reset[2] = 1'b0;
        #1;
        chk(ready[2] === 1'b1, "rs_ready", 10'(ready[2]), 10'd1);
        chk(u_ws3.mar_r === 7'd0, "rs_mar", 10'(u_ws3.mar_r), 10'd0);
        chk(u_ws3.mdr_r === 10'd0, "rs_mdr", u_ws3.mdr_r, 10'd0);
        model_reset(2);
        @(negedge clock);
        n_reset[2] = 1'b1;
        @(negedge clock);
        strobe(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h042, "rs_rmar");
        strobe(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000, "rs_rd");
        mdr_bus[2] = 1'b1; #1; b = bus2;
        chk(b === 10'h155, "rs_mem_kept", b, 10'h155);
        mdr_bus[2] = 1'b0;

        // Randomised traffic against the model on the 0- and 2-wait-state instances.
        for (int d = 0; d < 2; d++) begin
            for (int a = 64; a < 128; a++) begin
                strobe(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'(a), "ini_mar");
                strobe(d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'($urandom), "ini_mdr");
                strobe(d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, "ini_wr");
            end
            for (int n = 0; n < 200; n++) begin
                int op;
                logic [9:0] v;
                op = $urandom_range(0, 8);
                v = 10'($urandom);
                case (op)
                    0, 1: begin
                        v[6:0] = 7'($urandom_range(60, 127));
                        if ($urandom_range(0, 5) == 0) v[6:0] = 7'd80;
                        strobe(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v, "rnd_mar");
                    end
                    2: strobe(d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v, "rnd_inc");
                    3: strobe(d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, v, "rnd_mdr");
                    4, 5: strobe(d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v, "rnd_wr");
                    6, 7: strobe(d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, v, "rnd_rd");
                    default: strobe(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                    1'($urandom_range(0, 1)), v, "rnd_mix");
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
